fft_frame_arb: RTL and testbench
================================

Name: fft_frame_arb

Overview:
- Schedules the shared windowed-FFT datapath between two sample-buffer requesters, e.g. the left and right sensor channels.
- Grants one requester at a time using round-robin arbitration.
- Streams that requester's NPTS-sample frame from its synchronous buffer into the FFT input port.
- Tags and counts the returning FFT bins, then signals frame completion to the requester.
- Sits between the per-channel capture buffers and the FFT processing block.

Parameters:
NPTS, 1024, samples per frame (power of two)
AW, 10, address/bin index width, log2(NPTS)
DW, 16, input sample width per I/Q component
TMO, 4096, max idle cycles between FFT output samples in DRAIN before abort

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
REQ0  in  1  channel 0 has a full frame ready (level)
REQ1  in  1  channel 1 has a full frame ready (level)
GNT0  out  1  channel 0 owns the FFT (held WAIT_RDY..DRAIN)
GNT1  out  1  channel 1 owns the FFT
RDADD  out  AW  shared read address to both channel buffers
RDDAT0I  in  DW  channel 0 buffer I data, 1-cycle read latency
RDDAT0Q  in  DW  channel 0 buffer Q data
RDDAT1I  in  DW  channel 1 buffer I data
RDDAT1Q  in  DW  channel 1 buffer Q data
FFTBUSY  in  1  FFT input not ready or FFT output active
FFTDOE  out  1  FFT input sample valid
FFTDATI  out  DW  FFT input I
FFTDATQ  out  DW  FFT input Q
OFFTDOE  in  1  FFT output sample valid
BINVLD  out  1  qualifies BINIDX/BINCH, copy of OFFTDOE in DRAIN
BINIDX  out  AW  bin index of current FFT output sample
BINCH  out  1  channel owning current bins
DONE0  out  1  1-cycle pulse: channel 0 frame fully transformed
DONE1  out  1  1-cycle pulse: channel 1 frame fully transformed
ERR  out  1  sticky: overrun or timeout; cleared only by reset

Behaviour:
- Reset values: all outputs 0. State IDLE, round-robin pointer = channel 0. Reset mid-frame aborts immediately; no DONE is pulsed.
- States: IDLE, WAIT_RDY, FEED, DRAIN.
- IDLE:
  - If any REQ is high, grant the requester at the pointer if it requests, else the other one.
  - Set GNTx and BINCH next cycle, then go to WAIT_RDY.
  - OFFTDOE in IDLE is ignored.
- WAIT_RDY: when FFTBUSY=0, go to FEED with the address counter at 0.
- FEED:
  - RDADD steps 0..NPTS-1, one per cycle, contiguous.
  - At cycle t+2 relative to RDADD=a: FFTDOE=1 and FFTDATI/Q = registered granted channel data for address a.
  - After RDADD=NPTS-1 the address counter stops. The state moves to DRAIN once the last FFTDOE has been issued (pipeline flush of 2 cycles).
  - FFTDOE is exactly NPTS consecutive cycles, with no gaps.
  - FFTBUSY=1 during FEED sets ERR; feeding continues (no stall).
- DRAIN:
  - The bin counter starts at 0. Each OFFTDOE cycle: BINVLD=1, BINIDX=counter (combinationally aligned with OFFTDOE), then counter+1.
  - On the OFFTDOE with counter=NPTS-1: pulse DONEx next cycle, drop GNTx, toggle the pointer to the other channel, go to IDLE.
  - The idle counter resets on every OFFTDOE. When it reaches TMO: set ERR, drop GNTx, go to IDLE without DONE. The pointer still toggles.
- REQx is sampled only in IDLE. Deassertion after grant is ignored; the frame completes.
- Simultaneous REQ0 and REQ1: the pointer decides.
- DONE pulse and new arbitration: the IDLE decision occurs in the cycle after DONE; there is no back-to-back grant in the DONE cycle.
- RDADD holds its last value outside FEED.
- FFTDATI/Q are 0 when FFTDOE=0.
- GNT0 and GNT1 are never both high.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, WAIT_RDY=2'd1, FEED=2'd2, DRAIN=2'd3);
  - channel id constants;
  - NPTS/AW defaults.
- One natural sub-module: rr_arb2, the two-requester round-robin arbiter with pointer update on a grant-release pulse.
- The rest (address counter, 2-stage read pipeline, bin counter, timeout counter) stays in the top level.

Test Plan:
- Only REQ0=1, FFTBUSY=0, buffer0[a]=a -> GNT0 next cycle; FFTDOE high for exactly 1024 cycles with FFTDATI=0..1023; model returns 1024 OFFTDOE -> BINIDX 0..1023, BINCH=0, single DONE0, ERR=0.
- REQ0=REQ1=1 held continuously -> frames alternate ch0, ch1, ch0; each DONE matches its GNT; GNT0 and GNT1 are never both high.
- FFTBUSY=1 for 50 cycles after grant -> FFTDOE stays 0 until 2 cycles after FFTBUSY falls, then 1024 contiguous samples.
- FFTBUSY pulsed high at FEED sample 300 -> ERR=1 and remains set; frame still completes with DONE.
- Model emits only 500 OFFTDOE then stops -> TMO cycles later ERR=1, GNT drops, no DONE, next REQ1 frame runs normally.
- RST_N asserted at FEED sample 600 -> all outputs 0 immediately; after release, REQ0 restarts the frame from RDADD=0.

Source files
------------

// File: rtl/fft_frame_arb_pkg.sv
// Shared definitions for the FFT frame arbiter: FSM encoding, channel ids and
// default frame geometry.
package fft_frame_arb_pkg;

    localparam int NPTS_DEF = 1024;
    localparam int AW_DEF   = 10;
    localparam int DW_DEF   = 16;
    localparam int TMO_DEF  = 4096;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RDY = 2'd1,
        FEED     = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

endpackage

// File: rtl/fft_frame_arb_if.sv
// Bundle of requester, buffer-read, FFT-input and bin-tag signals around the
// arbiter; master is the arbiter side, slave the surrounding system.
interface fft_frame_arb_if #(
    parameter int AW = 10,
    parameter int DW = 16
);
    logic                 REQ0;
    logic                 REQ1;
    logic                 GNT0;
    logic                 GNT1;
    logic [AW-1:0]        RDADD;
    logic signed [DW-1:0] RDDAT0I;
    logic signed [DW-1:0] RDDAT0Q;
    logic signed [DW-1:0] RDDAT1I;
    logic signed [DW-1:0] RDDAT1Q;
    logic                 FFTBUSY;
    logic                 FFTDOE;
    logic signed [DW-1:0] FFTDATI;
    logic signed [DW-1:0] FFTDATQ;
    logic                 OFFTDOE;
    logic                 BINVLD;
    logic [AW-1:0]        BINIDX;
    logic                 BINCH;
    logic                 DONE0;
    logic                 DONE1;
    logic                 ERR;

    modport master (
        input  REQ0, REQ1, RDDAT0I, RDDAT0Q, RDDAT1I, RDDAT1Q, FFTBUSY, OFFTDOE,
        output GNT0, GNT1, RDADD, FFTDOE, FFTDATI, FFTDATQ,
               BINVLD, BINIDX, BINCH, DONE0, DONE1, ERR
    );

    modport slave (
        output REQ0, REQ1, RDDAT0I, RDDAT0Q, RDDAT1I, RDDAT1Q, FFTBUSY, OFFTDOE,
        input  GNT0, GNT1, RDADD, FFTDOE, FFTDATI, FFTDATQ,
               BINVLD, BINIDX, BINCH, DONE0, DONE1, ERR
    );

endinterface

// File: rtl/fft_frame_arb_rr_arb2.sv
// Two-requester round-robin arbiter (rr_arb2): the pointer moves to the channel
// opposite the one just released, so a waiting peer wins the next tie.
module fft_frame_arb_rr_arb2
    import fft_frame_arb_pkg::*;
(
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [1:0] req,
    input  logic       rel,
    input  logic       rel_ch,
    output logic       sel,
    output logic       any
);
    logic ptr;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr <= CH0;
        end else if (rel) begin
            ptr <= ~rel_ch;
        end
    end

    always_comb begin
        any = |req;
        sel = req[ptr] ? ptr : ~ptr;
    end

endmodule

// File: rtl/fft_frame_arb.sv
// Grants the shared FFT to one of two capture buffers, streams its frame into
// the FFT and tags/counts the returning bins until the frame is complete.
module fft_frame_arb
    import fft_frame_arb_pkg::*;
#(
    parameter int NPTS = NPTS_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF,
    parameter int TMO  = TMO_DEF
) (
    input logic             CLK,
    input logic             RST_N,
    fft_frame_arb_if.master bus
);
    localparam int            TW        = $clog2(TMO);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NPTS - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TMO - 1);

    state_t               state;
    logic                 ch;
    logic                 gnt0, gnt1, done0, done1, err;
    logic [AW-1:0]        addr_p0;
    logic                 vld_p0, vld_p1, vld_p2;
    logic signed [DW-1:0] dati_p2, datq_p2;
    logic [AW-1:0]        bin_cnt;
    logic [TW-1:0]        tmo_cnt;
    logic                 arb_sel, arb_any, rel, last_bin, tmo_hit;

    fft_frame_arb_rr_arb2 u_arb (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .req    ({bus.REQ1, bus.REQ0}),
        .rel    (rel),
        .rel_ch (ch),
        .sel    (arb_sel),
        .any    (arb_any)
    );

    // The pointer must move on the same edge the FSM returns to IDLE, so an
    // immediate re-arbitration after a timeout already sees the new pointer.
    always_comb begin
        last_bin = (state == DRAIN) && bus.OFFTDOE && (bin_cnt == LAST_ADDR);
        tmo_hit  = (state == DRAIN) && !bus.OFFTDOE && (tmo_cnt == TMO_LAST);
        rel      = last_bin || tmo_hit;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            ch      <= CH0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            err     <= 1'b0;
            addr_p0 <= '0;
            vld_p0  <= 1'b0;
            bin_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: begin
                    // Holding off while DONE is high keeps the new decision one cycle later.
                    if (arb_any && !done0 && !done1) begin
                        ch    <= arb_sel;
                        gnt0  <= (arb_sel == CH0);
                        gnt1  <= (arb_sel == CH1);
                        state <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (!bus.FFTBUSY) begin
                        addr_p0 <= '0;
                        vld_p0  <= 1'b1;
                        state   <= FEED;
                    end
                end
                FEED: begin
                    if (bus.FFTBUSY) err <= 1'b1;
                    if (vld_p0) begin
                        if (addr_p0 == LAST_ADDR) vld_p0 <= 1'b0;
                        else                      addr_p0 <= addr_p0 + AW'(1);
                    end else if (!vld_p1 && vld_p2) begin
                        bin_cnt <= '0;
                        tmo_cnt <= '0;
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_bin) begin
                        done0   <= (ch == CH0);
                        done1   <= (ch == CH1);
                        gnt0    <= 1'b0;
                        gnt1    <= 1'b0;
                        bin_cnt <= '0;
                        state   <= IDLE;
                    end else if (tmo_hit) begin
                        err   <= 1'b1;
                        gnt0  <= 1'b0;
                        gnt1  <= 1'b0;
                        state <= IDLE;
                    end else if (bus.OFFTDOE) begin
                        bin_cnt <= bin_cnt + AW'(1);
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // p0 -> p1: address issued, buffer read in flight; p1 -> p2: capture read data.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            dati_p2 <= '0;
            datq_p2 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                dati_p2 <= (ch == CH1) ? bus.RDDAT1I : bus.RDDAT0I;
                datq_p2 <= (ch == CH1) ? bus.RDDAT1Q : bus.RDDAT0Q;
            end else begin
                dati_p2 <= '0;
                datq_p2 <= '0;
            end
        end
    end

    assign bus.GNT0    = gnt0;
    assign bus.GNT1    = gnt1;
    assign bus.RDADD   = addr_p0;
    assign bus.FFTDOE  = vld_p2;
    assign bus.FFTDATI = dati_p2;
    assign bus.FFTDATQ = datq_p2;
    assign bus.BINVLD  = (state == DRAIN) && bus.OFFTDOE;
    assign bus.BINIDX  = bin_cnt;
    assign bus.BINCH   = ch;
    assign bus.DONE0   = done0;
    assign bus.DONE1   = done1;
    assign bus.ERR     = err;

endmodule

// File: tb/tb_fft_frame_arb.sv
// Scoreboard bench for fft_frame_arb: a frame-level model predicts grants,
// FFT input samples, bin tags and DONE pulses; a monitor compares them.
module tb_fft_frame_arb;
    import fft_frame_arb_pkg::*;

    localparam int NPTS = 1024;
    localparam int AW   = 10;
    localparam int DW   = 16;
    localparam int TMO  = 4096;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;

    fft_frame_arb_if #(.AW(AW), .DW(DW)) bus ();

    fft_frame_arb #(.NPTS(NPTS), .AW(AW), .DW(DW), .TMO(TMO)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    logic signed [DW-1:0] b0i [NPTS];
    logic signed [DW-1:0] b0q [NPTS];
    logic signed [DW-1:0] b1i [NPTS];
    logic signed [DW-1:0] b1q [NPTS];

    // Synchronous capture buffers with one cycle of read latency.
    always @(posedge CLK) begin
        bus.RDDAT0I <= b0i[bus.RDADD];
        bus.RDDAT0Q <= b0q[bus.RDADD];
        bus.RDDAT1I <= b1i[bus.RDADD];
        bus.RDDAT1Q <= b1q[bus.RDADD];
    end

    int                checks = 0;
    int                errors = 0;
    int                model_ptr = 0;
    int                exp_gnt [$];
    logic [2*DW-1:0]   exp_data [$];
    int                exp_bin [$];
    int                exp_done [$];

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic longint all_outputs();
        return longint'({bus.GNT0, bus.GNT1, bus.RDADD, bus.FFTDOE, bus.FFTDATI, bus.FFTDATQ,
                         bus.BINVLD, bus.BINIDX, bus.BINCH, bus.DONE0, bus.DONE1, bus.ERR});
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    initial begin
        logic prev_gnt;
        int   e;
        prev_gnt = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                prev_gnt = 1'b0;
            end else begin
                chk("gnt_exclusive", bus.GNT0 & bus.GNT1, 0);
                if ((bus.GNT0 | bus.GNT1) && !prev_gnt) begin
                    if (exp_gnt.size() == 0) chk("gnt_unexpected", 1, 0);
                    else begin
                        e = exp_gnt.pop_front();
                        chk("gnt_channel", bus.GNT1, e);
                        chk("binch_at_grant", bus.BINCH, e);
                    end
                end
                prev_gnt = bus.GNT0 | bus.GNT1;
                if (bus.FFTDOE) begin
                    if (exp_data.size() == 0) chk("fftdoe_unexpected", 1, 0);
                    else chk("fft_sample", {bus.FFTDATI, bus.FFTDATQ}, exp_data.pop_front());
                end else begin
                    chk("fft_data_zero_when_idle", {bus.FFTDATI, bus.FFTDATQ}, 0);
                end
                if (bus.BINVLD) begin
                    if (exp_bin.size() == 0) chk("binvld_unexpected", 1, 0);
                    else chk("bin_tag", {bus.BINCH, bus.BINIDX}, exp_bin.pop_front());
                end
                if (bus.DONE0 | bus.DONE1) begin
                    if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
                    else begin
                        e = exp_done.pop_front();
                        chk("done_channel", {bus.DONE1, bus.DONE0}, (e == 1) ? 2 : 1);
                    end
                    chk("gnt_low_in_done_cycle", bus.GNT0 | bus.GNT1, 0);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic load_buffers(input bit ramp0);
        logic [31:0] r;
        for (int a = 0; a < NPTS; a++) begin
            r = $urandom;
            b0i[a] = r[DW-1:0];
            b0q[a] = r[2*DW-1:DW];
            r = $urandom;
            b1i[a] = r[DW-1:0];
            b1q[a] = r[2*DW-1:DW];
            if (ramp0) b0i[a] = DW'(a);
        end
    endtask

    // One frame as seen from outside: arbitration, feed, FFT response, completion.
    task automatic run_frame(input bit r0, input bit r1, input bit hold, input int exp_glat,
                             input int busy_cyc, input int pulse_at, input int rst_at,
                             input int n_out, input bit exp_err);
        int ch;
        int n;
        int gaps;
        bit flag;
        ch = (r0 && r1) ? model_ptr : (r1 ? 1 : 0);
        exp_gnt.push_back(ch);
        for (int a = 0; a < NPTS; a++)
            exp_data.push_back((ch == 1) ? {b1i[a], b1q[a]} : {b0i[a], b0q[a]});
        bus.FFTBUSY = (busy_cyc > 0);
        bus.REQ0 = r0;
        bus.REQ1 = r1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(bus.GNT0 | bus.GNT1) && n < 8);
        if (!(bus.GNT0 | bus.GNT1)) begin
            chk("grant_timeout", 0, 1);
            return;
        end
        chk("grant_latency", n, exp_glat);
        if (!hold) begin
            bus.REQ0 = 1'b0;
            bus.REQ1 = 1'b0;
        end
        if (busy_cyc > 0) begin
            flag = 1'b0;
            repeat (busy_cyc) begin
                @(negedge CLK);
                if (bus.FFTDOE) flag = 1'b1;
            end
            chk("fftdoe_held_while_busy", flag, 0);
        end
        bus.FFTBUSY = 1'b0;
        // FFTBUSY low seen this cycle -> RDADD=0 next cycle -> first sample two later.
        @(negedge CLK);
        flag = bus.FFTDOE;
        @(negedge CLK);
        flag = flag | bus.FFTDOE;
        chk("fftdoe_not_early", flag, 0);
        @(negedge CLK);
        chk("fftdoe_start", bus.FFTDOE, 1);
        gaps = 0;
        for (int i = 0; i < NPTS; i++) begin
            if (i > 0) @(negedge CLK);
            if (!bus.FFTDOE) gaps++;
            if (i == rst_at) begin
                #2 RST_N = 1'b0;
                #1 chk("outputs_zero_in_reset", all_outputs(), 0);
                exp_gnt.delete();
                exp_data.delete();
                exp_bin.delete();
                exp_done.delete();
                model_ptr = 0;
                idle(2);
                RST_N = 1'b1;
                return;
            end
            bus.FFTBUSY = (i == pulse_at);
        end
        chk("fftdoe_contiguous_gaps", gaps, 0);
        @(negedge CLK);
        chk("fftdoe_stops", bus.FFTDOE, 0);
        chk("rdadd_holds_last", bus.RDADD, NPTS - 1);
        chk("err_after_feed", bus.ERR, exp_err);
        if (n_out == NPTS) exp_done.push_back(ch);
        repeat (3) @(posedge CLK);
        #1;
        for (int k = 0; k < n_out; k++) begin
            exp_bin.push_back((ch << AW) | k);
            bus.OFFTDOE = 1'b1;
            @(posedge CLK);
            #1 bus.OFFTDOE = 1'b0;
            if (k < n_out - 1) begin
                repeat ($urandom_range(0, 1)) begin
                    @(posedge CLK);
                    #1;
                end
            end
        end
        if (n_out == NPTS) begin
            @(negedge CLK);
            chk("done_pulse", (ch == 1) ? bus.DONE1 : bus.DONE0, 1);
            chk("gnt_dropped_at_done", bus.GNT0 | bus.GNT1, 0);
        end else begin
            n = 0;
            do begin
                @(negedge CLK);
                n++;
            end while ((bus.GNT0 | bus.GNT1) && n < TMO + 20);
            chk("timeout_gnt_drop_window", (n >= TMO - 1) && (n <= TMO + 2), 1);
            chk("err_after_timeout", bus.ERR, 1);
            idle(3);
        end
        model_ptr = 1 - ch;
    endtask

    initial begin
        bus.REQ0 = 1'b0;
        bus.REQ1 = 1'b0;
        bus.FFTBUSY = 1'b0;
        bus.OFFTDOE = 1'b0;
        load_buffers(1'b1);
        RST_N = 1'b0;
        idle(3);
        chk("reset_outputs", all_outputs(), 0);
        RST_N = 1'b1;
        idle(2);

        // Lone channel 0 with a ramp buffer
        run_frame(1, 0, 0, 1, 0, -1, -1, NPTS, 0);
        idle(4);

        // Both channels requesting continuously: frames alternate
        load_buffers(1'b0);
        run_frame(1, 1, 1, 1, 0, -1, -1, NPTS, 0);
        run_frame(1, 1, 1, 2, 0, -1, -1, NPTS, 0);
        run_frame(1, 1, 0, 2, 0, -1, -1, NPTS, 0);
        idle(4);

        // FFT not ready for 50 cycles after grant
        load_buffers(1'b0);
        run_frame(0, 1, 0, 1, 50, -1, -1, NPTS, 0);
        idle(4);

        // Overrun pulse in the middle of the feed
        run_frame(1, 0, 0, 1, 0, 300, -1, NPTS, 1);
        idle(4);
        chk("err_sticky", bus.ERR, 1);

        RST_N = 1'b0;
        idle(2);
        chk("err_cleared_by_reset", bus.ERR, 0);
        RST_N = 1'b1;
        model_ptr = 0;
        idle(2);

        // FFT stops after 500 bins -> timeout, then channel 1 runs normally
        load_buffers(1'b0);
        run_frame(1, 0, 0, 1, 0, -1, -1, 500, 0);
        run_frame(0, 1, 0, 1, 0, -1, -1, NPTS, 1);
        idle(4);

        // Reset in the middle of the feed, then restart from address 0
        load_buffers(1'b0);
        run_frame(1, 0, 0, 1, 0, -1, 600, NPTS, 0);
        idle(3);
        chk("outputs_after_reset_release", all_outputs(), 0);
        run_frame(1, 0, 0, 1, 0, -1, -1, NPTS, 0);
        idle(6);

        chk("leftover_expected_events", exp_gnt.size() + exp_data.size() + exp_bin.size() + exp_done.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        errors++;
        $display("FAIL watchdog: time limit reached at %0t, required completion before it", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
